// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: direction one-hot codes, route-order enum and
// the dimension-ordered route function reused by later router stages.
package noc_pkg;

  localparam int DIR_W       = 5;
  // Widest coordinate the route function accepts; callers zero-extend into it.
  localparam int COORD_MAX_W = 8;

  localparam logic [DIR_W-1:0] DIR_E     = 5'b00001;
  localparam logic [DIR_W-1:0] DIR_W_    = 5'b00010;
  localparam logic [DIR_W-1:0] DIR_N     = 5'b00100;
  localparam logic [DIR_W-1:0] DIR_S     = 5'b01000;
  localparam logic [DIR_W-1:0] DIR_LOCAL = 5'b10000;

  typedef enum logic {
    MODE_XY = 1'b0,
    MODE_YX = 1'b1
  } route_mode_e;

  // Resolve one axis at a time; the first axis with a nonzero offset wins.
  function automatic logic [DIR_W-1:0] route_dir(
    input logic [COORD_MAX_W-1:0] x,
    input logic [COORD_MAX_W-1:0] y,
    input logic [COORD_MAX_W-1:0] rx,
    input logic [COORD_MAX_W-1:0] ry,
    input route_mode_e            mode
  );
    logic [DIR_W-1:0] x_dir;
    logic [DIR_W-1:0] y_dir;
    logic [DIR_W-1:0] dir;
    x_dir = (x > rx) ? DIR_E : ((x < rx) ? DIR_W_ : '0);
    y_dir = (y > ry) ? DIR_N : ((y < ry) ? DIR_S  : '0);
    if (mode == MODE_XY) begin
      dir = (x_dir != '0) ? x_dir : y_dir;
    end else begin
      dir = (y_dir != '0) ? y_dir : x_dir;
    end
    if (dir == '0) begin
      dir = DIR_LOCAL;
    end
    return dir;
  endfunction

endpackage

// File: rtl/route_fifo2.sv
// Two-entry FIFO of routed headers {addr, dir}; readiness comes only from the
// registered occupancy so the upstream handshake never sees downstream ready.
module route_fifo2
  import noc_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DIR_W-1:0]  push_dir,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [ADDR_W-1:0] pop_addr,
  output logic [DIR_W-1:0]  pop_dir
);

  logic [1:0]        count;
  logic [ADDR_W-1:0] head_addr;
  logic [DIR_W-1:0]  head_dir;
  logic [ADDR_W-1:0] tail_addr;
  logic [DIR_W-1:0]  tail_dir;
  logic              push;
  logic              pop;

  assign push_ready = (count != 2'd2);
  assign pop_valid  = (count != 2'd0);
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;
  assign pop_addr   = head_addr;
  assign pop_dir    = head_dir;

  // Head slot drives the outputs directly; tail only moves up on a pop from full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 2'd0;
      head_addr <= '0;
      head_dir  <= '0;
      tail_addr <= '0;
      tail_dir  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          count <= count + 2'd1;
          if (count == 2'd0) begin
            head_addr <= push_addr;
            head_dir  <= push_dir;
          end else begin
            tail_addr <= push_addr;
            tail_dir  <= push_dir;
          end
        end
        2'b01: begin
          count <= count - 2'd1;
          if (count == 2'd2) begin
            head_addr <= tail_addr;
            head_dir  <= tail_dir;
          end
        end
        2'b11: begin
          // Only reachable with one entry held: the new header becomes the head.
          head_addr <= push_addr;
          head_dir  <= push_dir;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/xy_route_unit.sv
// Route-computation stage for one mesh router input port: computes the output
// direction per header, drops out-of-mesh destinations and buffers two results.
module xy_route_unit
  import noc_pkg::*;
#(
  parameter int COORD_W  = 3,
  parameter int MESH_X   = 8,
  parameter int MESH_Y   = 8,
  parameter int ROUTER_X = 4,
  parameter int ROUTER_Y = 4,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*COORD_W-1:0] in_addr,
  input  logic                 in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*COORD_W-1:0] out_addr,
  output logic [DIR_W-1:0]     out_dir,
  output logic                 err_drop,
  output logic [CNT_W-1:0]     drop_cnt
);

  localparam int ADDR_W = 2 * COORD_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic [COORD_W-1:0] in_x;
  logic [COORD_W-1:0] in_y;
  logic               in_range;
  logic               accept;
  logic               drop;
  logic [DIR_W-1:0]   in_dir;

  assign in_x     = in_addr[COORD_W-1:0];
  assign in_y     = in_addr[ADDR_W-1:COORD_W];
  assign in_range = (int'(in_x) < MESH_X) && (int'(in_y) < MESH_Y);
  assign accept   = in_valid && in_ready;
  assign drop     = accept && !in_range;

  // Direction is fixed at accept time and travels with the entry.
  assign in_dir = route_dir(COORD_MAX_W'(in_x), COORD_MAX_W'(in_y),
                            COORD_MAX_W'(ROUTER_X), COORD_MAX_W'(ROUTER_Y),
                            route_mode_e'(in_mode));

  route_fifo2 #(
    .ADDR_W(ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_valid(in_valid && in_range),
    .push_ready(in_ready),
    .push_addr (in_addr),
    .push_dir  (in_dir),
    .pop_valid (out_valid),
    .pop_ready (out_ready),
    .pop_addr  (out_addr),
    .pop_dir   (out_dir)
  );

  // Out-of-range headers still complete the handshake; they only leave a trace here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_drop <= 1'b0;
      drop_cnt <= '0;
    end else begin
      err_drop <= drop;
      if (drop) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

endmodule

// File: tb/tb_xy_route_unit.sv
// Self-checking bench for xy_route_unit: a default 8x8 instance and a 6x7 instance
// (router at 2,3) that can see out-of-mesh destinations.
module tb_xy_route_unit;

  localparam int COORD_W = 3;
  localparam int ADDR_W  = 2 * COORD_W;
  localparam int CNT_W   = 8;
  localparam int BMX = 6;
  localparam int BMY = 7;
  localparam int BRX = 2;
  localparam int BRY = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_valid_b, in_mode, out_ready;
  logic [ADDR_W-1:0] in_addr;

  logic              in_ready, out_valid, err_drop;
  logic [ADDR_W-1:0] out_addr;
  logic [4:0]        out_dir;
  logic [CNT_W-1:0]  drop_cnt;

  logic              in_ready_b, out_valid_b, err_drop_b;
  logic [ADDR_W-1:0] out_addr_b;
  logic [4:0]        out_dir_b;
  logic [CNT_W-1:0]  drop_cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xy_route_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_dir(out_dir),
    .err_drop(err_drop), .drop_cnt(drop_cnt)
  );

  xy_route_unit #(
    .COORD_W(COORD_W), .MESH_X(BMX), .MESH_Y(BMY),
    .ROUTER_X(BRX), .ROUTER_Y(BRY), .CNT_W(CNT_W)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_addr(in_addr), .in_mode(in_mode), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_addr(out_addr_b), .out_dir(out_dir_b),
    .err_drop(err_drop_b), .drop_cnt(drop_cnt_b)
  );

  // Reference: offsets from the router, the selected axis first, else LOCAL.
  function automatic logic [4:0] ref_dir(int x, int y, int rx, int ry, bit yx);
    int dx;
    int dy;
    dx = x - rx;
    dy = y - ry;
    if (!yx) begin
      if (dx > 0) return 5'b00001;
      if (dx < 0) return 5'b00010;
      if (dy > 0) return 5'b00100;
      if (dy < 0) return 5'b01000;
    end else begin
      if (dy > 0) return 5'b00100;
      if (dy < 0) return 5'b01000;
      if (dx > 0) return 5'b00001;
      if (dx < 0) return 5'b00010;
    end
    return 5'b10000;
  endfunction

  function automatic logic [ADDR_W-1:0] mk_addr(int x, int y);
    logic [2:0] xs;
    logic [2:0] ys;
    xs = 3'(x);
    ys = 3'(y);
    return {ys, xs};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_valid_b = 1'b0;
    in_addr = '0; in_mode = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (out_addr !== '0) begin errors++; $display("FAIL reset_out_addr: got %0h expected 0", out_addr); end
    checks++; if (out_dir !== 5'b0) begin errors++; $display("FAIL reset_out_dir: got %b expected 00000", out_dir); end
    checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL reset_err_drop: got %0b expected 0", err_drop); end
    checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    checks++; if (drop_cnt_b !== '0) begin errors++; $display("FAIL reset_drop_cnt_b: got %0d expected 0", drop_cnt_b); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_route();
    int vx[6];
    int vy[6];
    bit vm[6];
    logic [4:0] vd[6];
    vx = '{6, 2, 6, 4, 4, 4};
    vy = '{1, 6, 1, 4, 4, 7};
    vm = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vd = '{5'b00001, 5'b00010, 5'b01000, 5'b10000, 5'b10000, 5'b00100};
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      int x;
      int y;
      bit m;
      logic [4:0] e;
      if (i < 6) begin
        x = vx[i]; y = vy[i]; m = vm[i]; e = vd[i];
      end else begin
        x = $urandom_range(0, 7); y = $urandom_range(0, 7); m = 1'($urandom_range(0, 1));
        e = ref_dir(x, y, 4, 4, m);
      end
      in_valid = 1'b1; in_addr = mk_addr(x, y); in_mode = m;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL route_bypass[%0d]: out_valid=%0b expected 0", i, out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL route_in_ready[%0d]: got %0b expected 1", i, in_ready); end
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_mode = 1'($urandom_range(0, 1)); in_addr = ADDR_W'($urandom);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL route_valid[%0d]: got %0b expected 1", i, out_valid); end
      checks++; if (out_addr !== mk_addr(x, y)) begin errors++; $display("FAIL route_addr[%0d]: got %0h expected %0h", i, out_addr, mk_addr(x, y)); end
      checks++; if (out_dir !== e) begin errors++; $display("FAIL route_dir[%0d] x=%0d y=%0d m=%0d: got %b expected %b", i, x, y, m, out_dir, e); end
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL route_drain[%0d]: out_valid=%0b expected 0", i, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] h[3];
    logic [4:0] hd[3];
    bit hm[3];
    for (int k = 0; k < 3; k++) begin
      int x;
      int y;
      x = $urandom_range(0, 7); y = $urandom_range(0, 7); hm[k] = 1'($urandom_range(0, 1));
      h[k] = mk_addr(x, y); hd[k] = ref_dir(x, y, 4, 4, hm[k]);
    end
    out_ready = 1'b0;
    in_valid = 1'b1; in_addr = h[0]; in_mode = hm[0];
    @(posedge clk);
    #1;
    checks++; if (out_addr !== h[0] || out_valid !== 1'b1) begin errors++; $display("FAIL bp_first: valid=%0b addr=%0h expected 1/%0h", out_valid, out_addr, h[0]); end
    in_addr = h[1]; in_mode = hm[1];
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %0b expected 0", in_ready); end
    in_addr = h[2]; in_mode = hm[2];
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready[%0d]: got %0b expected 0", c, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_addr !== h[0] || out_dir !== hd[0]) begin errors++; $display("FAIL bp_stable[%0d]: valid=%0b addr=%0h dir=%b expected 1/%0h/%b", c, out_valid, out_addr, out_dir, h[0], hd[0]); end
    end
    out_ready = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_pop_cycle_ready: got %0b expected 0", in_ready); end
    @(posedge clk);
    #1;
    checks++; if (out_addr !== h[1] || out_dir !== hd[1]) begin errors++; $display("FAIL bp_second: addr=%0h dir=%b expected %0h/%b", out_addr, out_dir, h[1], hd[1]); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_return: got %0b expected 1", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_addr !== h[2] || out_dir !== hd[2]) begin errors++; $display("FAIL bp_third: valid=%0b addr=%0h dir=%b expected 1/%0h/%b", out_valid, out_addr, out_dir, h[2], hd[2]); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %0b expected 0", out_valid); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      int x;
      int y;
      bit m;
      x = $urandom_range(0, 7); y = $urandom_range(0, 7); m = 1'($urandom_range(0, 1));
      in_valid = 1'b1; in_addr = mk_addr(x, y); in_mode = m;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %0b expected 1", i, in_ready); end
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b1 || out_addr !== mk_addr(x, y) || out_dir !== ref_dir(x, y, 4, 4, m)) begin
        errors++; $display("FAIL stream_out[%0d]: valid=%0b addr=%0h dir=%b expected 1/%0h/%b", i, out_valid, out_addr, out_dir, mk_addr(x, y), ref_dir(x, y, 4, 4, m));
      end
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end: got %0b expected 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b0; in_valid_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_addr = mk_addr($urandom_range(BMX, 7), $urandom_range(0, BMY - 1));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_addr = mk_addr($urandom_range(0, BMX - 1), $urandom_range(0, BMY - 1));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; in_valid_b = 1'b0;
    checks++; if (drop_cnt_b !== 8'd5) begin errors++; $display("FAIL ar_setup_cnt: got %0d expected 5", drop_cnt_b); end
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL ar_setup_full: valid=%0b ready=%0b expected 1/0", out_valid, in_ready); end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_valid_b !== 1'b0) begin errors++; $display("FAIL ar_valid: got %0b/%0b expected 0/0", out_valid, out_valid_b); end
    checks++; if (in_ready !== 1'b1 || in_ready_b !== 1'b1) begin errors++; $display("FAIL ar_count: ready=%0b/%0b expected 1/1", in_ready, in_ready_b); end
    checks++; if (drop_cnt_b !== '0) begin errors++; $display("FAIL ar_drop_cnt: got %0d expected 0", drop_cnt_b); end
    checks++; if (out_addr !== '0 || out_dir !== 5'b0) begin errors++; $display("FAIL ar_data: addr=%0h dir=%b expected 0/00000", out_addr, out_dir); end
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL ar_release: ready=%0b valid=%0b expected 1/0", in_ready, out_valid); end
  endtask

  task automatic test_range_drop();
    out_ready = 1'b1; in_valid_b = 1'b1; in_addr = mk_addr(7, 0);
    checks++; if (in_ready_b !== 1'b1) begin errors++; $display("FAIL drop_ready: got %0b expected 1", in_ready_b); end
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
    checks++; if (out_valid_b !== 1'b0) begin errors++; $display("FAIL drop_no_valid: got %0b expected 0", out_valid_b); end
    checks++; if (err_drop_b !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %0b expected 1", err_drop_b); end
    checks++; if (drop_cnt_b !== 8'd1) begin errors++; $display("FAIL drop_cnt_one: got %0d expected 1", drop_cnt_b); end
    @(posedge clk);
    #1;
    checks++; if (err_drop_b !== 1'b0) begin errors++; $display("FAIL drop_pulse_end: got %0b expected 0", err_drop_b); end
    in_valid_b = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) in_addr = mk_addr($urandom_range(BMX, 7), $urandom_range(0, 7));
      else in_addr = mk_addr($urandom_range(0, 7), 7);
      @(posedge clk);
    end
    #1;
    in_valid_b = 1'b0;
    checks++; if (drop_cnt_b !== 8'd255) begin errors++; $display("FAIL drop_saturate: got %0d expected 255", drop_cnt_b); end
    checks++; if (out_valid_b !== 1'b0) begin errors++; $display("FAIL drop_sat_valid: got %0b expected 0", out_valid_b); end
    @(posedge clk);
    #1;
    checks++; if (err_drop_b !== 1'b0 || drop_cnt_b !== 8'd255) begin errors++; $display("FAIL drop_sat_hold: err=%0b cnt=%0d expected 0/255", err_drop_b, drop_cnt_b); end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] qa[$];
    logic [4:0] qd[$];
    int cnt;
    bit last_drop;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cnt = 0;
    last_drop = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int x;
      int y;
      bit m;
      bit acc;
      bit pop;
      bit bad;
      x = $urandom_range(0, 7); y = $urandom_range(0, 7); m = 1'($urandom_range(0, 1));
      in_valid_b = ($urandom_range(0, 3) != 0);
      in_addr = mk_addr(x, y); in_mode = m;
      out_ready = ($urandom_range(0, 3) != 0);
      checks++; if (out_valid_b !== (qa.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %0b expected %0b", cyc, out_valid_b, qa.size() > 0); end
      if (qa.size() > 0) begin
        checks++; if (out_addr_b !== qa[0] || out_dir_b !== qd[0]) begin errors++; $display("FAIL rnd_head[%0d]: addr=%0h dir=%b expected %0h/%b", cyc, out_addr_b, out_dir_b, qa[0], qd[0]); end
      end
      checks++; if (in_ready_b !== (qa.size() != 2)) begin errors++; $display("FAIL rnd_ready[%0d]: got %0b expected %0b", cyc, in_ready_b, qa.size() != 2); end
      checks++; if (err_drop_b !== last_drop) begin errors++; $display("FAIL rnd_err[%0d]: got %0b expected %0b", cyc, err_drop_b, last_drop); end
      checks++; if (int'(drop_cnt_b) != cnt) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", cyc, drop_cnt_b, cnt); end
      acc = in_valid_b && (qa.size() != 2);
      pop = (qa.size() > 0) && out_ready;
      bad = (x >= BMX) || (y >= BMY);
      @(posedge clk);
      #1;
      if (pop) begin
        void'(qa.pop_front());
        void'(qd.pop_front());
      end
      if (acc && !bad) begin
        qa.push_back(mk_addr(x, y));
        qd.push_back(ref_dir(x, y, BRX, BRY, m));
      end
      last_drop = acc && bad;
      if (last_drop && cnt < 255) cnt++;
    end
    in_valid_b = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_route();
    test_backpressure();
    test_streaming();
    test_async_reset();
    test_range_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xy_route_unit.md
Name: xy_route_unit

Overview:
- Parametrised route-computation stage for a 2D mesh router input port.
- Accepts header flits over a valid/ready handshake and computes the one-hot output direction (E/W/N/S/LOCAL) from the destination coordinates and this router's position.
- Supports XY or YX dimension order, selected per flit.
- Buffers up to 2 routed headers toward the switch allocator, and drops and counts headers whose destination lies outside the mesh.

Parameters:
- COORD_W, 3, width of each coordinate field; address width = 2*COORD_W.
- MESH_X, 8, number of columns; valid X range 0..MESH_X-1.
- MESH_Y, 8, number of rows; valid Y range 0..MESH_Y-1.
- ROUTER_X, 4, this router's X coordinate.
- ROUTER_Y, 4, this router's Y coordinate.
- CNT_W, 8, width of the drop counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  header flit present.
- in_ready  out  1  unit can accept a header this cycle.
- in_addr  in  2*COORD_W  destination; [COORD_W-1:0]=X, [2*COORD_W-1:COORD_W]=Y.
- in_mode  in  1  0=XY order, 1=YX order; sampled with the flit.
- out_valid  out  1  head entry holds a routed header.
- out_ready  in  1  downstream accepts the head entry.
- out_addr  out  2*COORD_W  destination of the head entry.
- out_dir  out  5  one-hot direction of the head entry.
- err_drop  out  1  one-cycle pulse when an out-of-range header is dropped.
- drop_cnt  out  CNT_W  saturating count of dropped headers.

Behaviour:
- Reset: one clock, async active-low reset, ports clk and rst_n.
  - While rst_n=0: FIFO emptied (count=0), out_valid=0, out_addr=0, out_dir=0, err_drop=0, drop_cnt=0.
  - Reset takes effect immediately and is not clock-dependent.
  - Reset mid-operation discards all buffered entries.
- Direction encoding: E=5'b00001, W=5'b00010, N=5'b00100, S=5'b01000, LOCAL=5'b10000. Comparisons are unsigned.
- XY mode:
  - X>ROUTER_X: E. X<ROUTER_X: W.
  - Otherwise Y>ROUTER_Y: N; Y<ROUTER_Y: S; else LOCAL.
- YX mode: Y compared first (N/S), then X (E/W), else LOCAL.
- Direction is computed combinationally at accept time and stored with the entry. It is never recomputed.
- Accept: in_valid && in_ready on a rising edge.
- in_ready = (count != 2), derived from registered count only. It does not depend on out_ready in the same cycle.
- Latency: a header accepted at edge N is visible at the output with out_valid=1 after edge N when the FIFO was empty.
- Throughput is 1 header/cycle when out_ready stays high.
- Pop: out_valid && out_ready at an edge removes the head entry.
- Push and pop in the same edge leave count unchanged; order is strictly FIFO.
- When full (count=2), in_ready=0 even if a pop occurs that cycle. in_ready returns to 1 the cycle after the pop.
- out_addr and out_dir hold stable while out_valid=1 && out_ready=0.
- Out of range: X>=MESH_X or Y>=MESH_Y.
  - The header is still consumed (handshake completes) but not enqueued.
  - err_drop=1 for exactly the following cycle.
  - drop_cnt increments, saturating at 2^CNT_W-1 with no wrap.
- Simultaneous drop and pop: the pop proceeds normally and drop_cnt still increments.
- out_valid never depends combinationally on in_valid; there is no bypass path.
- in_mode is ignored when in_valid=0.

Decomposition:
- Shared package noc_pkg:
  - DIR_W=5.
  - Direction one-hot constants DIR_E/W/N/S/LOCAL.
  - Route-mode enum (MODE_XY=0, MODE_YX=1).
  - A pure function route_dir(x, y, rx, ry, mode), reused by later router stages.
- One sub-module: route_fifo2, a 2-entry FIFO of {addr, dir} with registered count, async active-low reset, and the handshake described above.
- Top level: route function, range check, and drop counter.

Test Plan (defaults: COORD_W=3, MESH 8x8, ROUTER (4,4), CNT_W=8):
- XY routing: in_addr X=6,Y=1, mode=0, out_ready=1 -> out_valid=1 one cycle after accept, out_dir=00001 (E). Then X=2,Y=6 -> 00010 (W).
- YX routing: X=6,Y=1, mode=1 -> out_dir=01000 (S). Then X=4,Y=4, either mode -> 10000 (LOCAL). Then X=4,Y=7 -> 00100 (N).
- Backpressure: out_ready=0, offer 3 headers back-to-back.
  - -> in_ready=0 after 2 accepts; out_addr/out_dir stable.
  - Raising out_ready drains entries in order.
  - in_ready returns 1 one cycle after the first pop.
- Streaming: out_ready=1, 16 consecutive valid headers -> 16 outputs on 16 consecutive cycles, in_ready held 1, order preserved.
- Range drop: MESH_X=6, header X=7,Y=0 -> handshake completes, no out_valid, err_drop pulses 1 cycle, drop_cnt 0->1.
  - 300 drops -> drop_cnt saturates at 255.
- Async reset: with 2 entries buffered and drop_cnt=5, pulse rst_n low mid-cycle -> out_valid, count and drop_cnt become 0 before the next clk edge, and in_ready=1 after release.
